// File: rtl/image_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : image_sequencer_if
// Brief    : Button/switch/vsync inputs and image select outputs of the image sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface image_sequencer_if;
    logic [3:0] btn_i;
    logic       auto_i;
    logic       vsync_i;
    logic [3:0] image_select_o;
    logic [1:0] current_image_o;

    modport master (
        output btn_i,
        output auto_i,
        output vsync_i,
        input  image_select_o,
        input  current_image_o
    );

    modport slave (
        input  btn_i,
        input  auto_i,
        input  vsync_i,
        output image_select_o,
        output current_image_o
    );
endinterface
`default_nettype wire

// File: rtl/image_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : image_sequencer
// Brief    : Debounced manual image selection plus frame-timed auto advance.
//            Optional macro IMAGE_SEQ_SHUFFLE_EN: LFSR-driven auto advance.
// Revision : 1.0 - initial release
// ============================================================================
module image_sequencer #(
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int FRAMES_PER_IMAGE = 300
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    image_sequencer_if.slave bus
);
    localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int              FC_W    = $clog2(FRAMES_PER_IMAGE + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_IMAGE - 1);

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    logic [3:0]      btn_s1_q, btn_s2_q;
    logic            auto_s1_q, auto_s2_q;
    logic            vsync_s1_q, vsync_s2_q, vsync_prev_q;
    logic [3:0]      db_level;
    logic [3:0]      db_prev_q;
    logic [3:0]      press;
    logic            tick;
    logic [1:0]      adv_idx;
    state_t          state_q, state_d;
    logic [FC_W-1:0] frame_q, frame_d;
    logic [3:0]      sel_q, sel_d;
    logic [1:0]      cur_q, cur_d;
    logic            adv;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            auto_s1_q    <= 1'b0;
            auto_s2_q    <= 1'b0;
            vsync_s1_q   <= 1'b0;
            vsync_s2_q   <= 1'b0;
            vsync_prev_q <= 1'b0;
            db_prev_q    <= '0;
        end else begin
            btn_s1_q     <= bus.btn_i;
            btn_s2_q     <= btn_s1_q;
            auto_s1_q    <= bus.auto_i;
            auto_s2_q    <= auto_s1_q;
            vsync_s1_q   <= bus.vsync_i;
            vsync_s2_q   <= vsync_s1_q;
            vsync_prev_q <= vsync_s2_q;
            db_prev_q    <= db_level;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            lvl_q, lvl_d;

        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (btn_s2_q[gi] != lvl_q) begin
                if (cnt_q == DB_LAST) begin
                    lvl_d = btn_s2_q[gi];
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign db_level[gi] = lvl_q;
    end

    assign press = db_level & ~db_prev_q;
    assign tick  = vsync_prev_q & ~vsync_s2_q;

`ifdef IMAGE_SEQ_SHUFFLE_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // A random pick that repeats the current image is bumped so the picture always changes.
    always_comb begin
        adv_idx = lfsr_q[1:0];
        if (adv_idx == cur_q) begin
            adv_idx = cur_q + 2'd1;
        end
    end
`else
    assign adv_idx = cur_q + 2'd1;
`endif

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        sel_d   = '0;
        cur_d   = cur_q;
        adv     = 1'b0;
        case (state_q)
            ST_MANUAL: begin
                frame_d = '0;
                if (auto_s2_q) begin
                    state_d = ST_AUTO;
                end
            end
            ST_AUTO: begin
                if (!auto_s2_q) begin
                    state_d = ST_MANUAL;
                    frame_d = '0;
                end else if (tick) begin
                    if (frame_q == FC_LAST) begin
                        adv     = 1'b1;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + FC_W'(1);
                    end
                end
            end
        endcase
        if (adv) begin
            cur_d = adv_idx;
            sel_d = 4'b0001 << adv_idx;
        end
        // Press overrides any advance; descending scan leaves the lowest index winning.
        if (|press) begin
            for (int i = 3; i >= 0; i--) begin
                if (press[i]) begin
                    cur_d = 2'(i);
                    sel_d = 4'b0001 << i;
                end
            end
            frame_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_MANUAL;
            frame_q <= '0;
            sel_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            sel_q   <= sel_d;
            cur_q   <= cur_d;
        end
    end

    assign bus.image_select_o  = sel_q;
    assign bus.current_image_o = cur_q;
endmodule
`default_nettype wire

// File: tb/tb_image_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_sequencer
// Brief    : Self-checking bench for image_sequencer (DEBOUNCE_CYCLES=4, FRAMES_PER_IMAGE=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_sequencer;
    localparam int DEB = 4;
    localparam int FPI = 3;
`ifdef IMAGE_SEQ_SHUFFLE_EN
    localparam bit SHUF = 1'b1;
`else
    localparam bit SHUF = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    image_sequencer_if bus ();

    image_sequencer #(
        .DEBOUNCE_CYCLES  (DEB),
        .FRAMES_PER_IMAGE (FPI)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [3:0] sel;
        logic [1:0] cur;
        bit         any;
    } exp_t;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] sel;
        logic [1:0] cur;
    } vec_t;

    exp_t       sb[$];
    exp_t       e;
    logic [1:0] last_cur = 2'd0;
    logic [3:0] seen     = 4'd0;
    logic [1:0] idx;
    bit         ok;
    vec_t       vecs[6];

    function automatic logic [1:0] oh2idx(input logic [3:0] s);
        oh2idx = s[1] ? 2'd1 : s[2] ? 2'd2 : s[3] ? 2'd3 : 2'd0;
    endfunction

    // Every nonzero select must match the head of the scoreboard in the very cycle it was expected.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse cyc=%0d actual=none required sel=%b at cyc=%0d", cyc, sb[0].sel, sb[0].at);
                e = sb.pop_front();
            end
            if (bus.image_select_o != 4'b0000) begin
                checks++;
                if (sb.size() == 0 || sb[0].at != cyc) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d actual sel=%b required none", cyc, bus.image_select_o);
                end else begin
                    e   = sb.pop_front();
                    idx = oh2idx(bus.image_select_o);
                    if (e.any)
                        ok = $onehot(bus.image_select_o) && idx != last_cur && bus.current_image_o == idx;
                    else
                        ok = bus.image_select_o == e.sel && bus.current_image_o == e.cur;
                    if (!ok) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d actual sel=%b cur=%0d required sel=%b cur=%0d any=%0d",
                                 cyc, bus.image_select_o, bus.current_image_o, e.sel, e.cur, e.any);
                    end
                end
                last_cur = bus.current_image_o;
                seen     = seen | bus.image_select_o;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int at, input logic [3:0] sel, input logic [1:0] cur, input bit any);
        exp_t x;
        x.at = at; x.sel = sel; x.cur = cur; x.any = any;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic vsync_fall(input bit adv, input logic [3:0] sel, input logic [1:0] cur);
        bus.vsync_i = 1'b0;
        if (adv) expect_at(cyc + 3, sel, cur, SHUF);
        step(2);
        bus.vsync_i = 1'b1;
        step(6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{btn: 4'b0100, sel: 4'b0100, cur: 2'd2};
        vecs[1] = '{btn: 4'b0110, sel: 4'b0010, cur: 2'd1};
        vecs[2] = '{btn: 4'b0001, sel: 4'b0001, cur: 2'd0};
        vecs[3] = '{btn: 4'b1000, sel: 4'b1000, cur: 2'd3};
        vecs[4] = '{btn: 4'b1011, sel: 4'b0001, cur: 2'd0};
        vecs[5] = '{btn: 4'b1100, sel: 4'b0100, cur: 2'd2};

        bus.btn_i   = 4'b0000;
        bus.auto_i  = 1'b0;
        bus.vsync_i = 1'b1;
        step(5);
        chk("reset_sel", int'(bus.image_select_o), 0);
        chk("reset_cur", int'(bus.current_image_o), 0);
        rst_n = 1'b1;
        step(100);

        // Manual presses: pulse 7 cycles after the press, no repeat while held, nothing on release.
        foreach (vecs[i]) begin
            bus.btn_i = vecs[i].btn;
            expect_at(cyc + DEB + 3, vecs[i].sel, vecs[i].cur, 1'b0);
            step(20);
            chk("hold_cur", int'(bus.current_image_o), int'(vecs[i].cur));
            bus.btn_i = 4'b0000;
            step(12);
        end

        bus.btn_i = 4'b1000;
        expect_at(cyc + DEB + 3, 4'b1000, 2'd3, 1'b0);
        step(20);
        bus.btn_i = 4'b0000;
        step(12);

        // Bounce: level never stable long enough to be accepted.
        for (int k = 0; k < 10; k++) begin
            bus.btn_i[1] = ~bus.btn_i[1];
            step(2);
        end
        bus.btn_i = 4'b0000;
        step(12);
        chk("bounce_cur", int'(bus.current_image_o), 3);

        // Auto wrap 3 -> 0 -> 1.
        bus.auto_i = 1'b1;
        step(5);
        vsync_fall(1'b0, 4'b0000, 2'd0);
        vsync_fall(1'b0, 4'b0000, 2'd0);
        vsync_fall(1'b1, 4'b0001, 2'd0);
        vsync_fall(1'b0, 4'b0000, 2'd0);
        vsync_fall(1'b0, 4'b0000, 2'd0);
        vsync_fall(1'b1, 4'b0010, 2'd1);

        // Press of button 3 lands in the same cycle as the advancing tick.
        vsync_fall(1'b0, 4'b0000, 2'd0);
        vsync_fall(1'b0, 4'b0000, 2'd0);
        bus.btn_i = 4'b1000;
        expect_at(cyc + DEB + 3, 4'b1000, 2'd3, 1'b0);
        step(4);
        vsync_fall(1'b0, 4'b0000, 2'd0);
        vsync_fall(1'b0, 4'b0000, 2'd0);
        vsync_fall(1'b0, 4'b0000, 2'd0);
        vsync_fall(1'b1, 4'b0001, 2'd0);
        bus.btn_i = 4'b0000;
        step(12);

`ifdef IMAGE_SEQ_SHUFFLE_EN
        seen = 4'b0000;
        for (int k = 0; k < 40; k++) begin
            vsync_fall(1'b0, 4'b0000, 2'd0);
            vsync_fall(1'b0, 4'b0000, 2'd0);
            vsync_fall(1'b1, 4'b0000, 2'd0);
        end
        chk("shuffle_all_seen", int'(seen), 15);
`endif

        bus.auto_i = 1'b0;
        step(5);

        // Reset mid-debounce discards progress; debounce restarts from the release of reset.
        bus.btn_i = 4'b0100;
        step(4);
        rst_n = 1'b0;
        step(2);
        chk("midreset_sel", int'(bus.image_select_o), 0);
        chk("midreset_cur", int'(bus.current_image_o), 0);
        last_cur = 2'd0;
        rst_n = 1'b1;
        expect_at(cyc + DEB + 3, 4'b0100, 2'd2, 1'b0);
        step(20);
        bus.btn_i = 4'b0000;
        step(12);

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
